// File: rtl/reg_file_sb.sv
// Register file with per-register busy scoreboard, write-first bypass and a post-reset clear sweep.
// Read data is registered with 1-cycle latency; busy1/busy2 come combinationally from the current state.
module reg_file_sb #(
  parameter int N        = 16,
  parameter int ADDR_W   = 3,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_enable,
  input  logic [ADDR_W-1:0] read_addr1,
  input  logic [ADDR_W-1:0] read_addr2,
  output logic [N-1:0]      read_data1,
  output logic [N-1:0]      read_data2,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [N-1:0]      write_data,
  input  logic              reserve_enable,
  input  logic [ADDR_W-1:0] reserve_addr,
  output logic              busy1,
  output logic              busy2,
  output logic              ready
);
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {INIT, RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]      mem_q [DEPTH];
  logic [N-1:0]      mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [N-1:0]      rd1_q, rd1_d, rd2_q, rd2_d;
  logic              wr_ok, rsv_ok;

  // With ZERO_REG, register 0 silently drops writes and reserves.
  assign wr_ok  = write_enable   && !(ZERO_REG && write_addr   == '0);
  assign rsv_ok = reserve_enable && !(ZERO_REG && reserve_addr == '0);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    mem_d   = mem_q;
    busy_d  = busy_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    if (state_q == INIT) begin
      mem_d[ptr_q]  = '0;
      busy_d[ptr_q] = 1'b0;
      ptr_d         = ptr_q + 1'b1;
      rd1_d         = '0;
      rd2_d         = '0;
      if (ptr_q == ADDR_W'(DEPTH - 1)) state_d = RUN;
    end else begin
      if (read_enable) begin
        rd1_d = (wr_ok && write_addr == read_addr1) ? write_data : mem_q[read_addr1];
        rd2_d = (wr_ok && write_addr == read_addr2) ? write_data : mem_q[read_addr2];
      end
      if (wr_ok) begin
        mem_d[write_addr]  = write_data;
        busy_d[write_addr] = 1'b0;
      end
      // Reserve is applied after the write so it wins on an address collision.
      if (rsv_ok) busy_d[reserve_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      ptr_q   <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      mem_q   <= mem_d;
      busy_q  <= busy_d;
    end
  end

  assign read_data1 = rd1_q;
  assign read_data2 = rd2_q;
  assign ready      = (state_q == RUN);
  assign busy1      = (state_q == RUN) && busy_q[read_addr1];
  assign busy2      = (state_q == RUN) && busy_q[read_addr2];

endmodule
